path_replay_tracker: RTL and testbench
======================================

// Module: path_replay_tracker
// PURPOSE
//  Consumer of the solved-path direction stream (2-bit moves) popped from the rat's path queue.
//  Replays each move from the start cell, tracks the rat position, and counts moves.
//  Flags a bad path: a step leaving the grid or too many moves.
//  Reports whether the replayed path ends on the goal cell, for the top-level controller/display.
// PARAMETERS
//  COORD_W  4    width of x and y coordinates (grid is 2^COORD_W square)
//  CNT_W    9    width of move counter (covers 256 path entries plus margin)
//  START_X  0    replay start x;  START_Y 0  replay start y
//  GOAL_X   15   goal x;          GOAL_Y 15  goal y
// PORTS
//  clk         in   1        system clock, all state changes on posedge
//  rst         in   1        synchronous active-high reset
//  start       in   1        begin a replay (accepted in IDLE, DONE, ERR)
//  dir_valid   in   1        dir_in holds a valid move
//  dir_in      in   2        move: 00 right(x+1), 01 up(y-1), 10 left(x-1), 11 down(y+1)
//  path_end    in   1        queue exhausted (finish flag from path queue)
//  dir_ready   out  1        tracker accepts a move this cycle
//  pos_x       out  COORD_W  current x
//  pos_y       out  COORD_W  current y
//  move_count  out  CNT_W    moves accepted since last start
//  busy        out  1        high in RUN
//  done        out  1        high in DONE (replay finished cleanly)
//  success     out  1        valid with done: final position == (GOAL_X,GOAL_Y)
//  error       out  1        high in ERR
//  err_code    out  2        01 out of range, 10 count overflow, 11 revisit (loop check only)
// BEHAVIOUR
//  Reset: state IDLE; pos=(START_X,START_Y), move_count=0; dir_ready, busy, done, success, error=0.
//   err_code=00.
//  rst overrides everything incl. mid-replay; no partial state survives.
//  FSM: IDLE, RUN, DONE, ERR; all outputs registered or decoded from state only.
//  IDLE/DONE/ERR + start -> RUN next edge.
//   On entry: pos=start cell, move_count=0; success, err_code cleared.
//  RUN: dir_ready=1, busy=1. start is ignored.
//  Handshake: a move is accepted on an edge where dir_valid & dir_ready.
//   pos and move_count update on that same edge (1-cycle latency to outputs).
//  Move arithmetic is COORD_W-bit, with no wrap allowed.
//   Right at x=max, left at x=0, up at y=0, or down at y=max -> ERR, err_code=01.
//   Position stays at the last legal cell; move_count is not incremented.
//  move_count at all-ones with another accepted move -> ERR, err_code=10. Count holds at max.
//  path_end in RUN with no move accepted -> DONE.
//   success = (pos_x==GOAL_X && pos_y==GOAL_Y), registered on that edge.
//  path_end and an accepted move in the same cycle: apply the move first.
//   Then go to DONE, with success computed on the updated position.
//   If that move is illegal, ERR wins.
//  DONE/ERR: dir_ready=0; pos, count, success, err_code held until start or rst.
//  A zero-move path (path_end in first RUN cycle) -> DONE.
//   success=1 only if start cell == goal cell.
// CONFIGURATION
//  PATH_LOOP_CHECK_EN defined:
//   2^(2*COORD_W)-bit visited bitmap, cleared on RUN entry with the start cell marked.
//   An accepted move into an already-marked cell -> ERR, err_code=11. Position is not updated.
//   Otherwise the target cell is marked on the accept edge.
//   Out-of-range is checked before revisit.
//  PATH_LOOP_CHECK_EN undefined: no bitmap; revisits are legal; err_code 11 is never produced.
// TESTING
//  rst=1 one edge -> pos=(0,0), count=0, dir_ready=0, done=error=0.
//  start; stream 15x00 then 15x11 with dir_valid=1, then path_end ->
//   pos=(15,15), count=30, done=1, success=1.
//  start; dirs 00,11; path_end -> pos=(1,1), count=2, done=1, success=0.
//  start; dir 01 at (0,0) -> error=1, err_code=01, pos=(0,0), count=0, dir_ready=0 next cycle.
//  start; dir 00 with path_end in same cycle -> pos=(1,0), count=1, DONE, success=0.
//   Then rst mid-RUN on a restarted replay -> IDLE, pos=(0,0).
//  PATH_LOOP_CHECK_EN: dirs 00,10 -> ERR, err_code=11, pos=(1,0), count=1.
//   Without the macro the same dirs give pos=(0,0), count=2, still RUN.

Source files
------------

// File: rtl/path_replay_tracker.sv
// Replays a stream of 2-bit moves from the start cell, tracking position and move count,
// flagging out-of-grid steps and count overflow. Optional revisit check: PATH_LOOP_CHECK_EN.
module path_replay_tracker #(
    parameter int COORD_W = 4,
    parameter int CNT_W   = 9,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               dir_valid,
    input  logic [1:0]         dir_in,
    input  logic               path_end,
    output logic               dir_ready,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [CNT_W-1:0]   move_count,
    output logic               busy,
    output logic               done,
    output logic               success,
    output logic               error,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GOAL_X_C  = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GOAL_Y_C  = COORD_W'(GOAL_Y);
    localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t               state_r, state_s;
    logic [COORD_W-1:0]   pos_x_r, pos_x_s, pos_y_r, pos_y_s;
    logic [COORD_W-1:0]   tgt_x_s, tgt_y_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic                 success_r, success_s;
    logic [1:0]           err_code_r, err_code_s;
    logic                 oob_s;
    logic                 revisit_s;

    // Target cell of the presented move and whether it would leave the grid
    always_comb begin
        tgt_x_s = pos_x_r;
        tgt_y_s = pos_y_r;
        oob_s   = 1'b0;
        case (dir_in)
            2'b00: begin
                oob_s   = (pos_x_r == COORD_MAX);
                tgt_x_s = pos_x_r + COORD_ONE;
            end
            2'b01: begin
                oob_s   = (pos_y_r == '0);
                tgt_y_s = pos_y_r - COORD_ONE;
            end
            2'b10: begin
                oob_s   = (pos_x_r == '0);
                tgt_x_s = pos_x_r - COORD_ONE;
            end
            2'b11: begin
                oob_s   = (pos_y_r == COORD_MAX);
                tgt_y_s = pos_y_r + COORD_ONE;
            end
            default: begin
                oob_s   = 1'b1;
                tgt_x_s = pos_x_r;
                tgt_y_s = pos_y_r;
            end
        endcase
    end

`ifdef PATH_LOOP_CHECK_EN
    localparam int VIS_W = 1 << (2 * COORD_W);

    logic [VIS_W-1:0] visited_r;
    logic             enter_run_s;
    logic             move_ok_s;

    assign enter_run_s = (state_r != ST_RUN) && start;
    assign move_ok_s   = (state_r == ST_RUN) && dir_valid && !oob_s
                         && (cnt_r != CNT_MAX) && !revisit_s;
    assign revisit_s   = visited_r[{tgt_y_s, tgt_x_s}];

    // Visited-cell bitmap: start cell seeded on replay entry, targets marked on legal moves
    always_ff @(posedge clk) begin
        if (rst) begin
            visited_r <= '0;
        end else if (enter_run_s) begin
            visited_r                       <= '0;
            visited_r[{START_Y_C, START_X_C}] <= 1'b1;
        end else if (move_ok_s) begin
            visited_r[{tgt_y_s, tgt_x_s}] <= 1'b1;
        end else begin
            visited_r <= visited_r;
        end
    end
`else
    assign revisit_s = 1'b0;
`endif

    // Next state and datapath; an illegal move always wins over a simultaneous path_end
    always_comb begin
        state_s    = state_r;
        pos_x_s    = pos_x_r;
        pos_y_s    = pos_y_r;
        cnt_s      = cnt_r;
        success_s  = success_r;
        err_code_s = err_code_r;
        case (state_r)
            ST_RUN: begin
                if (dir_valid) begin
                    if (oob_s) begin
                        state_s    = ST_ERR;
                        err_code_s = 2'b01;
                    end else if (cnt_r == CNT_MAX) begin
                        state_s    = ST_ERR;
                        err_code_s = 2'b10;
                    end else if (revisit_s) begin
                        state_s    = ST_ERR;
                        err_code_s = 2'b11;
                    end else begin
                        pos_x_s = tgt_x_s;
                        pos_y_s = tgt_y_s;
                        cnt_s   = cnt_r + CNT_ONE;
                        if (path_end) begin
                            state_s   = ST_DONE;
                            success_s = (tgt_x_s == GOAL_X_C) && (tgt_y_s == GOAL_Y_C);
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end else if (path_end) begin
                    state_s   = ST_DONE;
                    success_s = (pos_x_r == GOAL_X_C) && (pos_y_r == GOAL_Y_C);
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_s    = ST_RUN;
                    pos_x_s    = START_X_C;
                    pos_y_s    = START_Y_C;
                    cnt_s      = '0;
                    success_s  = 1'b0;
                    err_code_s = 2'b00;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pos_x_r    <= START_X_C;
            pos_y_r    <= START_Y_C;
            cnt_r      <= '0;
            success_r  <= 1'b0;
            err_code_r <= 2'b00;
        end else begin
            state_r    <= state_s;
            pos_x_r    <= pos_x_s;
            pos_y_r    <= pos_y_s;
            cnt_r      <= cnt_s;
            success_r  <= success_s;
            err_code_r <= err_code_s;
        end
    end

    assign pos_x      = pos_x_r;
    assign pos_y      = pos_y_r;
    assign move_count = cnt_r;
    assign success    = success_r;
    assign err_code   = err_code_r;
    assign dir_ready  = (state_r == ST_RUN);
    assign busy       = (state_r == ST_RUN);
    assign done       = (state_r == ST_DONE);
    assign error      = (state_r == ST_ERR);

endmodule

// File: tb/tb_path_replay_tracker.sv
// Self-checking bench for path_replay_tracker: directed vector table, hand sequences, and
// randomized stimulus against an integer-level grid-walk model. Honors PATH_LOOP_CHECK_EN.
module tb_path_replay_tracker;

    localparam int GRID  = 16;
    localparam int GMAX  = GRID - 1;
    localparam int CMAX  = 511;
    localparam int GX    = 15;
    localparam int GY    = 15;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic       path_end = 1'b0;
    logic       dir_ready;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [8:0] move_count;
    logic       busy;
    logic       done;
    logic       success;
    logic       error;
    logic [1:0] err_code;

    path_replay_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir_valid  (dir_valid),
        .dir_in     (dir_in),
        .path_end   (path_end),
        .dir_ready  (dir_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .move_count (move_count),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int m_state = M_IDLE;
    int mx = 0;
    int my = 0;
    int mcnt = 0;
    int m_succ = 0;
    int m_code = 0;
    bit visited [GRID*GRID];

    typedef struct {
        int s; int v; int d; int pe;
        int ex; int ey; int ec;
        int erdy; int edone; int esucc; int eerr; int ecode;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input int s, v, d, pe, ex, ey, ec,
                                 input int erdy, edone, esucc, eerr, ecode);
        vec_t t;
        t.s = s; t.v = v; t.d = d; t.pe = pe;
        t.ex = ex; t.ey = ey; t.ec = ec;
        t.erdy = erdy; t.edone = edone; t.esucc = esucc; t.eerr = eerr; t.ecode = ecode;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Grid walk described by coordinates and plain integer bounds
    task automatic model_step(input bit r, s, v, input bit [1:0] d, input bit pe);
        int nx, ny;
        if (r) begin
            m_state = M_IDLE; mx = 0; my = 0; mcnt = 0; m_succ = 0; m_code = 0;
        end else if (m_state != M_RUN) begin
            if (s) begin
                m_state = M_RUN; mx = 0; my = 0; mcnt = 0; m_succ = 0; m_code = 0;
                foreach (visited[i]) visited[i] = 1'b0;
                visited[0] = 1'b1;
            end
        end else if (v) begin
            nx = mx + ((d == 2'd0) ? 1 : (d == 2'd2) ? -1 : 0);
            ny = my + ((d == 2'd3) ? 1 : (d == 2'd1) ? -1 : 0);
            if (nx < 0 || nx > GMAX || ny < 0 || ny > GMAX) begin
                m_state = M_ERR; m_code = 1;
            end else if (mcnt == CMAX) begin
                m_state = M_ERR; m_code = 2;
`ifdef PATH_LOOP_CHECK_EN
            end else if (visited[ny*GRID + nx]) begin
                m_state = M_ERR; m_code = 3;
`endif
            end else begin
                mx = nx; my = ny; mcnt++;
                visited[ny*GRID + nx] = 1'b1;
                if (pe) begin
                    m_state = M_DONE; m_succ = (mx == GX && my == GY) ? 1 : 0;
                end
            end
        end else if (pe) begin
            m_state = M_DONE; m_succ = (mx == GX && my == GY) ? 1 : 0;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".pos_x"},      pos_x,      mx);
        chk({tag, ".pos_y"},      pos_y,      my);
        chk({tag, ".move_count"}, move_count, mcnt);
        chk({tag, ".dir_ready"},  dir_ready,  (m_state == M_RUN));
        chk({tag, ".busy"},       busy,       (m_state == M_RUN));
        chk({tag, ".done"},       done,       (m_state == M_DONE));
        chk({tag, ".error"},      error,      (m_state == M_ERR));
        chk({tag, ".success"},    success,    m_succ);
        chk({tag, ".err_code"},   err_code,   m_code);
    endtask

    task automatic cycle(input string tag, input bit r, s, v, input bit [1:0] d, input bit pe);
        rst = r; start = s; dir_valid = v; dir_in = d; path_end = pe;
        model_step(r, s, v, d, pe);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    initial begin
        // Reset and its documented values
        cycle("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("rst.pos_x", pos_x, 0);
        chk("rst.pos_y", pos_y, 0);
        chk("rst.count", move_count, 0);
        chk("rst.dir_ready", dir_ready, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        chk("rst.err_code", err_code, 0);

        //               s v d pe  x y c  rdy dn sc er code
        vecs.push_back(mkv(1,0,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(0,1,0,0, 1,0,1, 1,0,0,0,0));
        vecs.push_back(mkv(0,1,3,0, 1,1,2, 1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,1, 1,1,2, 0,1,0,0,0));
        vecs.push_back(mkv(0,1,0,0, 1,1,2, 0,1,0,0,0));
        vecs.push_back(mkv(1,0,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(0,1,1,0, 0,0,0, 0,0,0,1,1));
        vecs.push_back(mkv(0,1,2,1, 0,0,0, 0,0,0,1,1));
        vecs.push_back(mkv(1,0,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(0,1,0,1, 1,0,1, 0,1,0,0,0));
        vecs.push_back(mkv(1,0,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(0,1,2,1, 0,0,0, 0,0,0,1,1));
        vecs.push_back(mkv(1,1,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(1,1,0,0, 1,0,1, 1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,1, 1,0,1, 0,1,0,0,0));
        vecs.push_back(mkv(1,0,0,0, 0,0,0, 1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,1, 0,0,0, 0,1,0,0,0));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cycle(tag, 1'b0, vecs[i].s[0], vecs[i].v[0], vecs[i].d[1:0], vecs[i].pe[0]);
            chk({tag, ".x"},     pos_x,      vecs[i].ex);
            chk({tag, ".y"},     pos_y,      vecs[i].ey);
            chk({tag, ".cnt"},   move_count, vecs[i].ec);
            chk({tag, ".rdy"},   dir_ready,  vecs[i].erdy);
            chk({tag, ".done"},  done,       vecs[i].edone);
            chk({tag, ".succ"},  success,    vecs[i].esucc);
            chk({tag, ".err"},   error,      vecs[i].eerr);
            chk({tag, ".code"},  err_code,   vecs[i].ecode);
        end

        // Full diagonal-corner path to the goal
        cycle("goal.start", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) cycle("goal.right", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) cycle("goal.down", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cycle("goal.end", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("goal.x", pos_x, 15);
        chk("goal.y", pos_y, 15);
        chk("goal.cnt", move_count, 30);
        chk("goal.done", done, 1);
        chk("goal.success", success, 1);

        // Immediate back-step: revisit behaviour depends on the loop check
        cycle("loop.start", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle("loop.right", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cycle("loop.left", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
`ifdef PATH_LOOP_CHECK_EN
        chk("loop.error", error, 1);
        chk("loop.code", err_code, 3);
        chk("loop.x", pos_x, 1);
        chk("loop.cnt", move_count, 1);
`else
        chk("loop.busy", busy, 1);
        chk("loop.x", pos_x, 0);
        chk("loop.cnt", move_count, 2);
`endif

        // Reset in the middle of a restarted replay
        cycle("mid.start", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        cycle("mid.move", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        cycle("mid.rst", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
        chk("mid.busy", busy, 0);
        chk("mid.y", pos_y, 0);
        chk("mid.cnt", move_count, 0);

`ifndef PATH_LOOP_CHECK_EN
        // Move counter saturation via back-and-forth steps
        cycle("ovf.start", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < CMAX; i++)
            cycle("ovf.walk", 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 2'd0 : 2'd2, 1'b0);
        chk("ovf.cnt_max", move_count, CMAX);
        chk("ovf.busy", busy, 1);
        cycle("ovf.extra", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        chk("ovf.error", error, 1);
        chk("ovf.code", err_code, 2);
        chk("ovf.cnt_hold", move_count, CMAX);
        chk("ovf.x", pos_x, 1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit r, s, v, pe;
            bit [1:0] d;
            r  = ($urandom_range(0, 299) == 0);
            s  = (m_state != M_RUN) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            v  = ($urandom_range(0, 9) < 7);
            d  = 2'($urandom_range(0, 3));
            pe = ($urandom_range(0, 39) == 0);
            cycle("rand", r, s, v, d, pe);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
